// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, interconnect FSM states and a one-hot priority helper.
package ahb_lite_pkg;

   localparam int MAX_SLAVES = 16;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   localparam logic OKAY  = 1'b0;
   localparam logic ERROR = 1'b1;

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      ERR_1  = 2'b01,
      ERR_2  = 2'b10
   } ic_state_t;

   // Keeps only the least-significant set bit, so the lowest slave index wins an overlap.
   function automatic logic [MAX_SLAVES-1:0] onehot_lowest(input logic [MAX_SLAVES-1:0] vec);
      return vec & (~vec + 16'd1);
   endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational base/mask address decoder: per-slave match vector, lowest winning index and hit flag.
module ahb_addr_decoder
   import ahb_lite_pkg::*;
#(
   parameter int                         N_SLAVES  = 3,
   parameter int                         ADDR_W    = 32,
   parameter int                         IDX_W     = 2,
   parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDR = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
   parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASK = {3{32'hFFFF_F000}}
)(
   input  logic [ADDR_W-1:0]   addr,
   output logic [N_SLAVES-1:0] match,
   output logic [IDX_W-1:0]    idx,
   output logic                hit
);

   // Compare the masked address against every slave window.
   always_comb begin
      match = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         match[i] = ((addr & ADDR_MASK[i*ADDR_W +: ADDR_W]) == BASE_ADDR[i*ADDR_W +: ADDR_W]);
      end
   end

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         idx = match[i] ? IDX_W'(i) : idx;
      end
   end

   assign hit = |match;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-lite interconnect: decode, data-phase response mux, default ERROR slave,
// wait-state watchdog and sticky first-error capture.
module ahb_lite_interconnect
   import ahb_lite_pkg::*;
#(
   parameter int                         N_SLAVES  = 3,
   parameter int                         ADDR_W    = 32,
   parameter int                         DATA_W    = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDR = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
   parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASK = {3{32'hFFFF_F000}},
   parameter int                         TIMEOUT   = 16
)(
   input  logic                       HCLK,
   input  logic                       HRESET,
   input  logic [ADDR_W-1:0]          HADDR,
   input  logic [1:0]                 HTRANS,
   output logic [N_SLAVES-1:0]        HSEL,
   input  logic [N_SLAVES-1:0]        HREADYOUT_S,
   input  logic [N_SLAVES-1:0]        HRESP_S,
   input  logic [N_SLAVES*DATA_W-1:0] HRDATA_S,
   output logic                       HREADY,
   output logic                       HRESP,
   output logic [DATA_W-1:0]          HRDATA,
   input  logic                       err_clr,
   output logic                       err_valid,
   output logic                       err_cause,
   output logic [ADDR_W-1:0]          err_addr
);

   localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   logic [N_SLAVES-1:0] match_s;
   logic [IDX_W-1:0]    win_idx_s;
   logic                hit_s;
   logic                active_s;
   logic                slave_ready_s;
   logic                slave_resp_s;
   logic [DATA_W-1:0]   slave_rdata_s;
   logic                hready_s;
   logic                hresp_s;
   logic [DATA_W-1:0]   hrdata_s;
   logic                wait_en_s;
   logic [CNT_W-1:0]    wait_inc_s;
   logic                timeout_s;
   logic                miss_s;
   logic                err_entry_s;

   ic_state_t           state_r;
   logic [IDX_W-1:0]    dsel_r;
   logic                dvalid_r;
   logic                dactive_r;
   logic [ADDR_W-1:0]   daddr_r;
   logic [CNT_W-1:0]    wait_cnt_r;
   logic                err_valid_r;
   logic                err_cause_r;
   logic [ADDR_W-1:0]   err_addr_r;

   ahb_addr_decoder #(
      .N_SLAVES  (N_SLAVES),
      .ADDR_W    (ADDR_W),
      .IDX_W     (IDX_W),
      .BASE_ADDR (BASE_ADDR),
      .ADDR_MASK (ADDR_MASK)
   ) u_decoder (
      .addr  (HADDR),
      .match (match_s),
      .idx   (win_idx_s),
      .hit   (hit_s)
   );

   assign HSEL          = N_SLAVES'(onehot_lowest(MAX_SLAVES'(match_s)));
   assign active_s      = (HTRANS == NONSEQ) || (HTRANS == SEQ);
   assign slave_ready_s = HREADYOUT_S[dsel_r];
   assign slave_resp_s  = HRESP_S[dsel_r];
   assign slave_rdata_s = HRDATA_S[dsel_r*DATA_W +: DATA_W];

   // Merge the data-phase response; the ERR states act as the built-in default slave.
   always_comb begin
      hready_s = 1'b1;
      hresp_s  = OKAY;
      hrdata_s = '0;
      if (HRESET) begin
         hready_s = 1'b1;
         hresp_s  = OKAY;
         hrdata_s = '0;
      end else begin
         case (state_r)
            NORMAL: begin
               if (dvalid_r) begin
                  hready_s = slave_ready_s;
                  hresp_s  = slave_resp_s;
                  hrdata_s = slave_rdata_s;
               end else begin
                  hready_s = 1'b1;
                  hresp_s  = OKAY;
                  hrdata_s = '0;
               end
            end
            ERR_1: begin
               hready_s = 1'b0;
               hresp_s  = ERROR;
               hrdata_s = '0;
            end
            ERR_2: begin
               hready_s = 1'b1;
               hresp_s  = ERROR;
               hrdata_s = '0;
            end
            default: begin
               hready_s = 1'b1;
               hresp_s  = OKAY;
               hrdata_s = '0;
            end
         endcase
      end
   end

   assign HREADY = hready_s;
   assign HRESP  = hresp_s;
   assign HRDATA = hrdata_s;

   // The timeout fires on the edge that completes the TIMEOUT-th wait cycle.
   assign wait_en_s   = (state_r == NORMAL) && dvalid_r && dactive_r && !slave_ready_s;
   assign wait_inc_s  = (wait_cnt_r == TMO) ? wait_cnt_r : wait_cnt_r + CNT_W'(1);
   assign timeout_s   = (TIMEOUT != 0) && wait_en_s && (wait_inc_s == TMO);
   assign miss_s      = hready_s && active_s && !hit_s;
   assign err_entry_s = miss_s || timeout_s;

   // Error-sequencing FSM.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r <= NORMAL;
      end else begin
         case (state_r)
            NORMAL:  state_r <= err_entry_s ? ERR_1 : NORMAL;
            ERR_1:   state_r <= ERR_2;
            ERR_2:   state_r <= miss_s ? ERR_1 : NORMAL;
            default: state_r <= NORMAL;
         endcase
      end
   end

   // Data-phase tracking; a timed-out slave is detached so its late responses are ignored.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_r    <= '0;
         dvalid_r  <= 1'b0;
         dactive_r <= 1'b0;
         daddr_r   <= '0;
      end else if (hready_s) begin
         dsel_r    <= win_idx_s;
         dvalid_r  <= hit_s;
         dactive_r <= active_s;
         daddr_r   <= HADDR;
      end else if (timeout_s) begin
         dvalid_r  <= 1'b0;
      end
   end

   // Watchdog wait counter, saturating at TIMEOUT.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt_r <= '0;
      end else if (hready_s) begin
         wait_cnt_r <= '0;
      end else if (wait_en_s) begin
         wait_cnt_r <= wait_inc_s;
      end
   end

   // Sticky capture of the first error; a clear coinciding with a new error keeps the new one.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_valid_r <= 1'b0;
         err_cause_r <= 1'b0;
         err_addr_r  <= '0;
      end else if (err_entry_s && (!err_valid_r || err_clr)) begin
         err_valid_r <= 1'b1;
         err_cause_r <= timeout_s;
         err_addr_r  <= timeout_s ? daddr_r : HADDR;
      end else if (err_clr) begin
         err_valid_r <= 1'b0;
      end
   end

   assign err_valid = err_valid_r;
   assign err_cause = err_cause_r;
   assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed self-checking bench: main instance with TIMEOUT=4 plus an overlapping-window instance.
module tb_ahb_lite_interconnect;
   import ahb_lite_pkg::*;

   localparam logic [95:0] OVL_BASE = {32'h0000_2000, 32'h0000_0000, 32'h0000_0000};

   logic        HCLK;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HREADYOUT_S;
   logic [2:0]  HRESP_S;
   logic [95:0] HRDATA_S;
   logic        err_clr;

   logic [2:0]  hsel;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;
   logic        err_valid;
   logic        err_cause;
   logic [31:0] err_addr;

   logic [2:0]  o_hsel;
   logic        o_hready;
   logic        o_hresp;
   logic [31:0] o_hrdata;
   logic        o_err_valid;
   logic        o_err_cause;
   logic [31:0] o_err_addr;

   int n_tests = 0;
   int n_fail  = 0;

   ahb_lite_interconnect #(.TIMEOUT(4)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(hsel),
      .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
      .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .err_clr(err_clr),
      .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr)
   );

   ahb_lite_interconnect #(.BASE_ADDR(OVL_BASE), .TIMEOUT(4)) u_ovl (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(o_hsel),
      .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
      .HREADY(o_hready), .HRESP(o_hresp), .HRDATA(o_hrdata), .err_clr(err_clr),
      .err_valid(o_err_valid), .err_cause(o_err_cause), .err_addr(o_err_addr)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESET      = 1'b1;
      HADDR       = 32'h0000_0000;
      HTRANS      = IDLE;
      HREADYOUT_S = 3'b111;
      HRESP_S     = 3'b000;
      HRDATA_S    = {32'hC2C2_0002, 32'hA5A5_0001, 32'hD0D0_0000};
      err_clr     = 1'b0;

      // Reset
      next_cycle();
      next_cycle();
      #1;
      check_eq("rst_hready", hready, 1'b1);
      check_eq("rst_hresp", hresp, 1'b0);
      check_eq("rst_hrdata", hrdata, 32'h0);
      check_eq("rst_err_valid", err_valid, 1'b0);
      check_eq("rst_err_addr", err_addr, 32'h0);
      HRESET = 1'b0;

      // Mapped read to slave 1 with one wait state
      HADDR = 32'h0000_1004; HTRANS = NONSEQ; HREADYOUT_S = 3'b101;
      #1;
      check_eq("rd_hsel", hsel, 3'b010);
      next_cycle();
      HADDR = 32'h0000_0000; HTRANS = IDLE;
      #1;
      check_eq("rd_wait_hready", hready, 1'b0);
      next_cycle();
      HREADYOUT_S = 3'b111;
      #1;
      check_eq("rd_hready", hready, 1'b1);
      check_eq("rd_hresp", hresp, 1'b0);
      check_eq("rd_hrdata", hrdata, 32'hA5A5_0001);
      next_cycle();

      // IDLE to an unmapped address: zero-wait OKAY, no capture
      HADDR = 32'h0000_8000; HTRANS = IDLE;
      next_cycle();
      check_eq("idle_miss_hready", hready, 1'b1);
      check_eq("idle_miss_hresp", hresp, 1'b0);
      check_eq("idle_miss_err_valid", err_valid, 1'b0);

      // Unmapped NONSEQ: two-cycle ERROR then OKAY
      HADDR = 32'h0000_8000; HTRANS = NONSEQ;
      #1;
      check_eq("miss_hsel", hsel, 3'b000);
      next_cycle();
      HADDR = 32'h0000_0000; HTRANS = IDLE;
      #1;
      check_eq("miss_e1_hready", hready, 1'b0);
      check_eq("miss_e1_hresp", hresp, 1'b1);
      check_eq("miss_err_valid", err_valid, 1'b1);
      check_eq("miss_err_cause", err_cause, 1'b0);
      check_eq("miss_err_addr", err_addr, 32'h0000_8000);
      next_cycle();
      check_eq("miss_e2_hready", hready, 1'b1);
      check_eq("miss_e2_hresp", hresp, 1'b1);
      next_cycle();
      check_eq("miss_done_hready", hready, 1'b1);
      check_eq("miss_done_hresp", hresp, 1'b0);

      // Back-to-back: new miss presented during ERR_2, first capture kept
      HADDR = 32'h0000_8000; HTRANS = NONSEQ;
      next_cycle();
      HTRANS = IDLE;
      next_cycle();
      HADDR = 32'h0000_9000; HTRANS = NONSEQ;
      #1;
      check_eq("b2b_e2_hresp", hresp, 1'b1);
      next_cycle();
      HADDR = 32'h0000_0000; HTRANS = IDLE;
      #1;
      check_eq("b2b_reenter_hready", hready, 1'b0);
      check_eq("b2b_reenter_hresp", hresp, 1'b1);
      check_eq("b2b_err_addr", err_addr, 32'h0000_8000);
      next_cycle();
      next_cycle();
      check_eq("b2b_done_hresp", hresp, 1'b0);

      // Clear the capture
      err_clr = 1'b1;
      next_cycle();
      err_clr = 1'b0;
      check_eq("clr_err_valid", err_valid, 1'b0);

      // Timeout: slave 2 stalls forever
      HADDR = 32'h0000_2000; HTRANS = NONSEQ; HREADYOUT_S = 3'b011;
      #1;
      check_eq("to_hsel", hsel, 3'b100);
      next_cycle();
      HADDR = 32'h0000_0000; HTRANS = IDLE;
      for (int k = 1; k <= 4; k++) begin
         #1;
         check_eq($sformatf("to_wait%0d_hready", k), hready, 1'b0);
         check_eq($sformatf("to_wait%0d_hresp", k), hresp, 1'b0);
         next_cycle();
      end
      HREADYOUT_S = 3'b111; HRESP_S = 3'b100;
      #1;
      check_eq("to_e1_hready", hready, 1'b0);
      check_eq("to_e1_hresp", hresp, 1'b1);
      check_eq("to_err_valid", err_valid, 1'b1);
      check_eq("to_err_cause", err_cause, 1'b1);
      check_eq("to_err_addr", err_addr, 32'h0000_2000);
      next_cycle();
      HREADYOUT_S = 3'b011; HRESP_S = 3'b000;
      #1;
      check_eq("to_e2_hready", hready, 1'b1);
      check_eq("to_e2_hresp", hresp, 1'b1);
      next_cycle();
      HREADYOUT_S = 3'b111; HRESP_S = 3'b100;
      #1;
      check_eq("to_late_hready", hready, 1'b1);
      check_eq("to_late_hresp", hresp, 1'b0);
      HRESP_S = 3'b000;

      // err_clr coincident with a new miss: the new error is captured
      err_clr = 1'b1; HADDR = 32'h0000_A000; HTRANS = NONSEQ;
      next_cycle();
      err_clr = 1'b0; HADDR = 32'h0000_0000; HTRANS = IDLE;
      #1;
      check_eq("clrmiss_hresp", hresp, 1'b1);
      check_eq("clrmiss_err_valid", err_valid, 1'b1);
      check_eq("clrmiss_err_cause", err_cause, 1'b0);
      check_eq("clrmiss_err_addr", err_addr, 32'h0000_A000);
      next_cycle();
      next_cycle();

      // Reset in the middle of an ERROR sequence
      HADDR = 32'h0000_8000; HTRANS = NONSEQ;
      next_cycle();
      HADDR = 32'h0000_0000; HTRANS = IDLE; HRESET = 1'b1;
      #1;
      check_eq("rstmid_hready", hready, 1'b1);
      check_eq("rstmid_hresp", hresp, 1'b0);
      next_cycle();
      HRESET = 1'b0;
      #1;
      check_eq("rstmid_after_hready", hready, 1'b1);
      check_eq("rstmid_after_hresp", hresp, 1'b0);
      check_eq("rstmid_err_valid", err_valid, 1'b0);
      check_eq("rstmid_err_addr", err_addr, 32'h0);

      // Overlapping windows: lowest index wins
      HADDR = 32'h0000_0010; HTRANS = NONSEQ;
      #1;
      check_eq("ovl_hsel", o_hsel, 3'b001);
      check_eq("main_hsel_0010", hsel, 3'b001);
      next_cycle();
      HADDR = 32'h0000_0000; HTRANS = IDLE;
      #1;
      check_eq("ovl_hready", o_hready, 1'b1);
      check_eq("ovl_hresp", o_hresp, 1'b0);
      check_eq("ovl_hrdata", o_hrdata, 32'hD0D0_0000);
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
